// File: rtl/v_widen_seq_pkg.sv
// Shared vALU sequencer types: SEW codes, sequencer state encoding and the held beat layout.
// Imported by the widening sequencer and its neighbours.
package v_widen_seq_pkg;

  localparam int VALU_DATA_W = 64;
  localparam int VALU_SEW_W  = 2;
  localparam int VALU_BE_W   = 8;
  localparam int VALU_ADDR_W = 5;

  localparam logic [VALU_SEW_W-1:0] SEW_8  = 2'b00;
  localparam logic [VALU_SEW_W-1:0] SEW_16 = 2'b01;
  localparam logic [VALU_SEW_W-1:0] SEW_32 = 2'b10;
  localparam logic [VALU_SEW_W-1:0] SEW_64 = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALF0 = 2'd1,
    HALF1 = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [VALU_DATA_W-1:0] vec0;
    logic [VALU_DATA_W-1:0] vec1;
    logic [VALU_SEW_W-1:0]  sew;
    logic [VALU_BE_W-1:0]   be;
    logic                   sgn;
    logic                   widen;
    logic [VALU_ADDR_W-1:0] addr;
  } beat_t;

  // 64-bit elements have nowhere wider to go, so a widen request at SEW_64 is not honoured.
  function automatic logic widen_legal(input logic widen, input logic [VALU_SEW_W-1:0] sew);
    return widen & (sew != SEW_64);
  endfunction

endpackage

// File: rtl/v_widen_seq.sv
// Splits each accepted source beat into one (plain) or two (widen: low then high half) beats for the widener.
// Output is registered; a new beat is accepted in the same cycle the final turn of the previous one is taken.
module v_widen_seq
  import v_widen_seq_pkg::*;
#(
  parameter int REQ_DATA_WIDTH    = VALU_DATA_W,
  parameter int SEW_WIDTH         = VALU_SEW_W,
  parameter int REQ_BYTE_EN_WIDTH = VALU_BE_W,
  parameter int ADDR_WIDTH        = VALU_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [REQ_DATA_WIDTH-1:0]    in_vec0,
  input  logic [REQ_DATA_WIDTH-1:0]    in_vec1,
  input  logic [SEW_WIDTH-1:0]         in_sew,
  input  logic [REQ_BYTE_EN_WIDTH-1:0] in_be,
  input  logic                         in_signed,
  input  logic                         in_widen,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [REQ_DATA_WIDTH-1:0]    out_vec0,
  output logic [REQ_DATA_WIDTH-1:0]    out_vec1,
  output logic [SEW_WIDTH-1:0]         out_sew,
  output logic [REQ_BYTE_EN_WIDTH-1:0] out_be,
  output logic                         out_signed,
  output logic                         out_widen,
  output logic                         out_turn,
  output logic                         out_last,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic                         out_err
);

  seq_state_e state_q, state_d;
  beat_t      beat_q, beat_d;
  logic       valid_q, valid_d;
  logic       turn_q, turn_d;
  logic       last_q, last_d;
  logic       err_q, err_d;

  logic fire;
  logic complete;
  logic accept;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    turn_d  = turn_q;
    last_d  = last_q;
    err_d   = err_q;

    fire     = valid_q & out_ready;
    complete = fire & last_q;
    in_ready = ~rst & ((state_q == IDLE) | complete);
    accept   = in_valid & in_ready;

    case (state_q)
      HALF0: begin
        if (fire && !last_q) begin
          state_d     = HALF1;
          turn_d      = 1'b1;
          last_d      = 1'b1;
          beat_d.addr = beat_q.addr + 1'b1;
        end else if (complete) begin
          state_d = IDLE;
          valid_d = 1'b0;
          turn_d  = 1'b0;
          last_d  = 1'b0;
        end
      end
      HALF1: begin
        if (complete) begin
          state_d = IDLE;
          valid_d = 1'b0;
          turn_d  = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: ;
    endcase

    // A load overrides the completion above so back-to-back beats never see a bubble.
    if (accept) begin
      state_d      = HALF0;
      valid_d      = 1'b1;
      turn_d       = 1'b0;
      beat_d.vec0  = in_vec0;
      beat_d.vec1  = in_vec1;
      beat_d.sew   = in_sew;
      beat_d.be    = in_be;
      beat_d.sgn   = in_signed;
      beat_d.widen = widen_legal(in_widen, in_sew);
      beat_d.addr  = in_addr;
      last_d       = ~widen_legal(in_widen, in_sew);
      if (in_widen && in_sew == SEW_64) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      valid_q <= 1'b0;
      turn_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      turn_q  <= turn_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_vec0   = beat_q.vec0;
  assign out_vec1   = beat_q.vec1;
  assign out_sew    = beat_q.sew;
  assign out_be     = beat_q.be;
  assign out_signed = beat_q.sgn;
  assign out_widen  = beat_q.widen;
  assign out_turn   = turn_q;
  assign out_last   = last_q;
  assign out_addr   = beat_q.addr;
  assign out_err    = err_q;

endmodule

// File: tb/tb_v_widen_seq.sv
// Scoreboarded bench for v_widen_seq: expected output beats are queued at accept time
// and matched against every beat the widener takes.
module tb_v_widen_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_vec0;
  logic [63:0] in_vec1;
  logic [1:0]  in_sew;
  logic [7:0]  in_be;
  logic        in_signed;
  logic        in_widen;
  logic [4:0]  in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_vec0;
  logic [63:0] out_vec1;
  logic [1:0]  out_sew;
  logic [7:0]  out_be;
  logic        out_signed;
  logic        out_widen;
  logic        out_turn;
  logic        out_last;
  logic [4:0]  out_addr;
  logic        out_err;

  typedef struct packed {
    logic [63:0] vec0;
    logic [63:0] vec1;
    logic [1:0]  sew;
    logic [7:0]  be;
    logic        sgn;
    logic        widen;
    logic        turn;
    logic        last;
    logic [4:0]  addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  v_widen_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vec0(in_vec0), .in_vec1(in_vec1), .in_sew(in_sew), .in_be(in_be),
    .in_signed(in_signed), .in_widen(in_widen), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec0(out_vec0), .out_vec1(out_vec1), .out_sew(out_sew), .out_be(out_be),
    .out_signed(out_signed), .out_widen(out_widen), .out_turn(out_turn),
    .out_last(out_last), .out_addr(out_addr), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: widen only when legal; the high-half beat targets addr+1 mod 32.
  function automatic void push_exp(input logic [63:0] v0, input logic [63:0] v1, input logic [1:0] sew,
                                   input logic [7:0] be, input logic sgn, input logic widen,
                                   input logic [4:0] addr);
    exp_t e;
    logic we;
    we      = widen && (sew != 2'b11);
    e.vec0  = v0;
    e.vec1  = v1;
    e.sew   = sew;
    e.be    = be;
    e.sgn   = sgn;
    e.widen = we;
    e.turn  = 1'b0;
    e.last  = !we;
    e.addr  = addr;
    sb.push_back(e);
    if (we) begin
      e.turn = 1'b1;
      e.last = 1'b1;
      e.addr = addr + 5'd1;
      sb.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      act = {out_vec0, out_vec1, out_sew, out_be, out_signed, out_widen, out_turn, out_last, out_addr};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: unexpected beat %h", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL sb_beat: got %h expected %h", act, e);
        end
      end
    end
  end

  task automatic drive_fields(input logic [63:0] v0, input logic [63:0] v1, input logic [1:0] sew,
                              input logic [7:0] be, input logic sgn, input logic widen,
                              input logic [4:0] addr);
    in_vec0   = v0;
    in_vec1   = v1;
    in_sew    = sew;
    in_be     = be;
    in_signed = sgn;
    in_widen  = widen;
    in_addr   = addr;
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic send_beat(input logic [63:0] v0, input logic [63:0] v1, input logic [1:0] sew,
                           input logic [7:0] be, input logic sgn, input logic widen,
                           input logic [4:0] addr);
    bit done;
    done = 0;
    drive_fields(v0, v1, sew, be, sgn, widen, addr);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(v0, v1, sew, be, sgn, widen, addr);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready never rose for addr %0d", addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive_fields(64'h0, 64'h0, 2'b00, 8'h00, 1'b0, 1'b0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_turn, out_last, out_err, in_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid/turn/last/err/in_ready=%b required 00000",
               {out_valid, out_turn, out_last, out_err, in_ready});
    end
    checks++;
    if ({out_vec0, out_vec1, out_addr} !== '0) begin
      errors++;
      $display("FAIL reset_data: vec0=%h vec1=%h addr=%0d required zero", out_vec0, out_vec1, out_addr);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_widen_basic();
    out_ready = 1'b1;
    send_beat(64'h8877665544332211, 64'h0102030405060708, 2'b00, 8'hff, 1'b1, 1'b1, 5'd4);
    @(negedge clk);
    checks++;
    if ({out_valid, out_turn, out_last, out_addr, in_ready} !== {1'b1, 1'b0, 1'b0, 5'd4, 1'b0}) begin
      errors++;
      $display("FAIL widen_turn0: valid=%b turn=%b last=%b addr=%0d in_ready=%b required 1 0 0 4 0",
               out_valid, out_turn, out_last, out_addr, in_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_turn, out_last, out_addr, out_vec0} !==
        {1'b1, 1'b1, 1'b1, 5'd5, 64'h8877665544332211}) begin
      errors++;
      $display("FAIL widen_turn1: valid=%b turn=%b last=%b addr=%0d vec0=%h required 1 1 1 5 8877665544332211",
               out_valid, out_turn, out_last, out_addr, out_vec0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    logic [63:0] v;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v = {$urandom, $urandom};
      drive_fields(v, ~v, i[1:0], 8'h0f << i, i[0], 1'b0, 5'(8 + i));
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready%0d: in_ready=%b required 1", i, in_ready);
      end else begin
        push_exp(v, ~v, i[1:0], 8'h0f << i, i[0], 1'b0, 5'(8 + i));
      end
      if (i > 0) begin
        checks++;
        if ({out_valid, out_last} !== 2'b11) begin
          errors++;
          $display("FAIL stream_valid%0d: valid=%b last=%b required 1 1", i, out_valid, out_last);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_last, out_addr} !== {1'b1, 1'b1, 5'd10}) begin
      errors++;
      $display("FAIL stream_tail: valid=%b last=%b addr=%0d required 1 1 10", out_valid, out_last, out_addr);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_idle: out_valid=%b required 0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    logic [63:0] v0;
    v0 = 64'hdead_beef_cafe_f00d;
    out_ready = 1'b1;
    send_beat(v0, 64'h1111_2222_3333_4444, 2'b01, 8'h3c, 1'b0, 1'b1, 5'd10);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive_fields(64'h5555, 64'h6666, 2'b10, 8'hf0, 1'b1, 1'b0, 5'd20);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_turn, out_last, out_addr, out_vec0, in_ready} !==
          {1'b1, 1'b1, 1'b1, 5'd11, v0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b turn=%b last=%b addr=%0d vec0=%h in_ready=%b required 1 1 1 11 %h 0",
                 i, out_valid, out_turn, out_last, out_addr, out_vec0, in_ready, v0);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: in_ready=%b required 1", in_ready);
    end else begin
      push_exp(64'h5555, 64'h6666, 2'b10, 8'hf0, 1'b1, 1'b0, 5'd20);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_turn, out_addr} !== {1'b1, 1'b0, 5'd20}) begin
      errors++;
      $display("FAIL stall_next_beat: valid=%b turn=%b addr=%0d required 1 0 20", out_valid, out_turn, out_addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send_beat(64'h0123_4567_89ab_cdef, 64'h0, 2'b11, 8'hff, 1'b1, 1'b1, 5'd7);
    @(negedge clk);
    checks++;
    if ({out_valid, out_widen, out_last, out_err} !== 4'b1011) begin
      errors++;
      $display("FAIL illegal_beat: valid=%b widen=%b last=%b err=%b required 1 0 1 1",
               out_valid, out_widen, out_last, out_err);
    end
    @(posedge clk);
    #1;
    send_beat(64'h77, 64'h88, 2'b01, 8'h0f, 1'b0, 1'b1, 5'd2);
    send_beat(64'h99, 64'haa, 2'b10, 8'hf0, 1'b1, 1'b0, 5'd3);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (out_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: out_err=%b required 1", out_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    send_beat(64'hffff_0000_ffff_0000, 64'h1, 2'b10, 8'hff, 1'b0, 1'b1, 5'd31);
    @(negedge clk);
    checks++;
    if ({out_turn, out_addr} !== {1'b0, 5'd31}) begin
      errors++;
      $display("FAIL wrap_turn0: turn=%b addr=%0d required 0 31", out_turn, out_addr);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_turn, out_addr} !== {1'b1, 1'b1, 5'd0}) begin
      errors++;
      $display("FAIL wrap_turn1: valid=%b turn=%b addr=%0d required 1 1 0", out_valid, out_turn, out_addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b1;
    send_beat(64'habcd, 64'hef01, 2'b10, 8'hff, 1'b0, 1'b1, 5'd12);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_turn, in_ready} !== 3'b110) begin
      errors++;
      $display("FAIL rst_mid_pre: valid=%b turn=%b in_ready=%b required 1 1 0", out_valid, out_turn, in_ready);
    end
    // The pending turn=1 beat is abandoned by the reset.
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_err, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rst_mid_post: valid=%b err=%b in_ready=%b required 0 0 1", out_valid, out_err, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_no_turn1_%0d: out_valid=%b required 0", i, out_valid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected beats never appeared required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_widen_basic();
    test_stream();
    test_stall();
    test_illegal();
    test_wrap();
    test_drain();
    test_rst_mid();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
